sample_feeder: RTL

Upstream stage of the perceptron training datapath. Holds up to DEPTH training samples (x1, x2, t) in an on-chip buffer loaded by the host. On command, it streams them to the neuron datapath as repeated epochs over a valid/ready handshake. It stops after a programmable epoch count, or at the end of the sample in flight once the downstream convergence flag is raised. It also drives the sample count `n`, which the datapath compares against for end-of-file detection.

---
 rtl/feeder_pkg.sv | 31 +++
 rtl/sample_ram.sv | 30 +++
 rtl/sample_feeder.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared types, widths and field offsets for the sample feeder
package feeder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_PRESENT = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int X_W      = 7;
   localparam int T_W      = 2;
   localparam int SAMPLE_W = 16;

   localparam int X1_LSB = 0;
   localparam int X2_LSB = 7;
   localparam int T_LSB  = 14;

   function automatic logic [X_W-1:0] get_x1(input logic [SAMPLE_W-1:0] w);
      return w[X1_LSB +: X_W];
   endfunction

   function automatic logic [X_W-1:0] get_x2(input logic [SAMPLE_W-1:0] w);
      return w[X2_LSB +: X_W];
   endfunction

   function automatic logic [T_W-1:0] get_t(input logic [SAMPLE_W-1:0] w);
      return w[T_LSB +: T_W];
   endfunction

endpackage

// File: rtl/sample_ram.sv
// rtl/sample_ram.sv - single-port sample buffer, synchronous write and 1-cycle read
module sample_ram #(
   parameter int DEPTH = 64,
   parameter int AW    = 6,
   parameter int W     = 16
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] rdata_q;

   // Storage array and read register; read data only changes when a read is issued
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/sample_feeder.sv
// rtl/sample_feeder.sv - buffers training samples and streams them as repeated epochs
module sample_feeder
   import feeder_pkg::*;
#(
   parameter int DEPTH   = 64,
   parameter int AW      = 6,
   parameter int EPOCH_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wrEn,
   input  logic [15:0]        wrData,
   input  logic               clear,
   input  logic               start,
   input  logic               stop,
   input  logic [EPOCH_W-1:0] maxEpochs,
   input  logic               ready,
   output logic               valid,
   output logic [6:0]         x1,
   output logic [6:0]         x2,
   output logic [1:0]         t,
   output logic               last,
   output logic [31:0]        n,
   output logic [EPOCH_W-1:0] epoch,
   output logic               busy,
   output logic               done,
   output logic               full
);

   state_t               state_q, state_d;
   logic [AW:0]          count_q, count_d;
   logic [AW-1:0]        ptr_q, ptr_d;
   logic [EPOCH_W-1:0]   epoch_q, epoch_d;
   logic [EPOCH_W-1:0]   limit_q, limit_d;
   logic                 stop_q, stop_d;
   // pre_q: the RAM read register already holds the sample at ptr_q
   logic                 pre_q, pre_d;
   logic [X_W-1:0]       x1_q, x1_d;
   logic [X_W-1:0]       x2_q, x2_d;
   logic [T_W-1:0]       t_q, t_d;

   logic                 ram_we;
   logic                 ram_re;
   logic [AW-1:0]        ram_addr;
   logic [SAMPLE_W-1:0]  ram_rdata;

   logic                 busy_w;
   logic                 full_w;
   logic                 is_last;
   logic                 stop_now;
   logic                 limit_hit;
   logic                 launch;
   logic [AW:0]          last_idx;
   logic [AW-1:0]        ptr_inc;
   logic [EPOCH_W-1:0]   epoch_inc;

   sample_ram #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .W     (SAMPLE_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (ram_addr),
      .wdata (wrData),
      .rdata (ram_rdata)
   );

   // Status decode shared by the next-state logic and the ports
   always_comb begin
      busy_w    = (state_q == ST_FETCH) || (state_q == ST_PRESENT);
      full_w    = (count_q == (AW+1)'(DEPTH));
      last_idx  = count_q - (AW+1)'(1);
      is_last   = ({1'b0, ptr_q} == last_idx);
      stop_now  = stop_q | stop;
      ptr_inc   = ptr_q + AW'(1);
      epoch_inc = (&epoch_q) ? epoch_q : epoch_q + EPOCH_W'(1);
      limit_hit = (limit_q != '0) &&
                  (((EPOCH_W+1)'(epoch_q) + (EPOCH_W+1)'(1)) == (EPOCH_W+1)'(limit_q));
   end

   // Next-state, buffer access and output-register loads
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      ptr_d    = ptr_q;
      epoch_d  = epoch_q;
      limit_d  = limit_q;
      stop_d   = stop_q | (stop & busy_w);
      pre_d    = pre_q;
      x1_d     = x1_q;
      x2_d     = x2_q;
      t_d      = t_q;
      ram_we   = 1'b0;
      ram_re   = 1'b0;
      ram_addr = ptr_q;
      launch   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               count_d = '0;
            end else if (start) begin
               launch = 1'b1;
            end else if (wrEn && !full_w) begin
               ram_we   = 1'b1;
               ram_addr = count_q[AW-1:0];
               count_d  = count_q + (AW+1)'(1);
            end
         end

         ST_FETCH: begin
            if (stop_q) begin
               state_d = ST_DONE;
            end else if (!pre_q) begin
               ram_re   = 1'b1;
               ram_addr = ptr_q;
               pre_d    = 1'b1;
            end else begin
               x1_d    = get_x1(ram_rdata);
               x2_d    = get_x2(ram_rdata);
               t_d     = get_t(ram_rdata);
               pre_d   = 1'b0;
               state_d = ST_PRESENT;
            end
         end

         ST_PRESENT: begin
            if (ready) begin
               if (is_last) begin
                  ptr_d   = '0;
                  epoch_d = epoch_inc;
                  if (stop_now || limit_hit) begin
                     state_d = ST_DONE;
                  end else begin
                     ram_re   = 1'b1;
                     ram_addr = '0;
                     pre_d    = 1'b1;
                     state_d  = ST_FETCH;
                  end
               end else begin
                  ptr_d = ptr_inc;
                  if (stop_now) begin
                     state_d = ST_DONE;
                  end else begin
                     ram_re   = 1'b1;
                     ram_addr = ptr_inc;
                     pre_d    = 1'b1;
                     state_d  = ST_FETCH;
                  end
               end
            end
         end

         ST_DONE: begin
            if (clear) begin
               count_d = '0;
               state_d = ST_IDLE;
            end else if (start) begin
               launch = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (launch) begin
         ptr_d   = '0;
         epoch_d = '0;
         stop_d  = 1'b0;
         pre_d   = 1'b0;
         limit_d = maxEpochs;
         state_d = (count_q != '0) ? ST_FETCH : ST_DONE;
      end
   end

   // State, counters and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         ptr_q   <= '0;
         epoch_q <= '0;
         limit_q <= '0;
         stop_q  <= 1'b0;
         pre_q   <= 1'b0;
         x1_q    <= '0;
         x2_q    <= '0;
         t_q     <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ptr_q   <= ptr_d;
         epoch_q <= epoch_d;
         limit_q <= limit_d;
         stop_q  <= stop_d;
         pre_q   <= pre_d;
         x1_q    <= x1_d;
         x2_q    <= x2_d;
         t_q     <= t_d;
      end
   end

   assign valid = (state_q == ST_PRESENT);
   assign last  = valid & is_last;
   assign x1    = x1_q;
   assign x2    = x2_q;
   assign t     = t_q;
   assign n     = 32'(count_q);
   assign epoch = epoch_q;
   assign busy  = busy_w;
   assign done  = (state_q == ST_DONE);
   assign full  = full_w;

endmodule
